// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG TDR driving the gate1 data mux override: captures the mux output,
// shifts it on the chain, and on update applies override data plus a held or self-timed select.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
  parameter int WIDTH        = 19,
  parameter int PULSE_CYCLES = 16
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] observe_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_in
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD, PULSE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH+2:0] sr;
  logic             pulse_mode_q;
  logic             expired_q;
  logic             set_expired;
  logic             cap, shf, upd;
  logic             req, mode;

  assign cap  = ijtag_sel & ijtag_ce;
  assign shf  = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign upd  = ijtag_sel & ijtag_ue;
  assign req  = sr[WIDTH];
  assign mode = sr[WIDTH+1];
  assign ijtag_so = sr[0];

  // An update always takes priority over the pulse countdown, so a cancel or
  // retrigger landing on the expiry edge suppresses the expired flag.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    set_expired = 1'b0;
    case (state)
      IDLE: begin
        if (upd && req) begin
          if (mode) begin
            state_nxt = PULSE;
            cnt_nxt   = RELOAD;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (upd) begin
          if (!req) begin
            state_nxt = IDLE;
          end else if (mode) begin
            state_nxt = PULSE;
            cnt_nxt   = RELOAD;
          end
        end
      end
      PULSE: begin
        if (upd) begin
          if (!req) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (mode) begin
            cnt_nxt   = RELOAD;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end
        end else if (cnt <= CW'(1)) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          set_expired = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Select is registered from the next state so it changes on the same edge as the override data.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ijtag_select <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ijtag_select <= (state_nxt != IDLE);
      if (set_expired) begin
        expired_q <= 1'b1;
      end else if (cap) begin
        expired_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr            <= '0;
      ijtag_data_in <= '0;
      pulse_mode_q  <= 1'b0;
    end else begin
      if (cap) begin
        sr <= {expired_q, pulse_mode_q, ijtag_select, observe_data_in};
      end else if (shf) begin
        sr <= {ijtag_si, sr[WIDTH+2:1]};
      end
      if (upd) begin
        ijtag_data_in <= sr[WIDTH-1:0];
        pulse_mode_q  <= sr[WIDTH+1];
      end
    end
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_ctrl.md
# firebird7_in_gate1_tessent_data_mux_ctrl

IJTAG test data register (TDR) that drives the override controls of the gate1 19-bit data mux. It captures the value observed on the mux output and shifts it out on the IJTAG chain. On update it applies a new override value and select. The select can be held static, or applied as a self-timed pulse of a fixed number of TCK cycles. It sits on the instrument's IJTAG segment, between the SIB-level scan path and the mux's `ijtag_select` / `ijtag_data_in` pins.

## Interface
- `WIDTH`, 19: width of the mux datapath.
- `PULSE_CYCLES`, 16: number of TCK cycles `ijtag_select` stays high in pulse mode. Must be ≥1. Counter width is clog2(PULSE_CYCLES+1).

Ports:
- `ijtag_tck` in 1: TCK. All state changes on its rising edge.
- `ijtag_reset` in 1: reset, asynchronous and active-low.
- `ijtag_sel` in 1: this TDR is on the active scan path. Gates `ijtag_ce`, `ijtag_se` and `ijtag_ue`.
- `ijtag_ce` in 1: capture enable.
- `ijtag_se` in 1: shift enable.
- `ijtag_ue` in 1: update enable.
- `ijtag_si` in 1: scan in.
- `ijtag_so` out 1: scan out, equal to `sr[0]` (registered).
- `observe_data_in` in WIDTH: the mux `data_out`, sampled on capture.
- `ijtag_select` out 1: drives the mux select. Registered.
- `ijtag_data_in` out WIDTH: override data to the mux. Registered.

## Operation
Shift register `sr` is WIDTH+3 bits:
- `[WIDTH-1:0]`: data.
- `[WIDTH]`: select request.
- `[WIDTH+1]`: pulse mode.
- `[WIDTH+2]`: pulse_expired status. Capture-only; its value is ignored on update.

Enable qualification: `ce`, `se` and `ue` act only when `ijtag_sel`=1. With `ijtag_sel`=0, `sr` and the update logic hold; the pulse counter still runs.

Each rising edge, with `ijtag_sel`=1, `sr` is updated as follows:
- Capture (`ce`=1): `sr` <= {expired_q, pulse_mode_q, `ijtag_select`, `observe_data_in`}. Capturing clears `expired_q` on the same edge.
- Shift (`se`=1, `ce`=0): `sr` <= {`ijtag_si`, sr[WIDTH+2:1]}. The LSB exits first.
- `ce`=`se`=1: capture wins.

Update (`ue`=1) is evaluated in parallel with capture/shift and uses the pre-edge `sr`:
- `ijtag_data_in` <= sr[WIDTH-1:0].
- `pulse_mode_q` <= sr[WIDTH+1].
- The state transition below is taken from sr[WIDTH] and sr[WIDTH+1].

FSM (`ijtag_select` = state≠IDLE):
- IDLE
  - Update with req=1, mode=0 → HOLD.
  - Update with req=1, mode=1 → PULSE, counter ← PULSE_CYCLES.
  - Update with req=0 → stays IDLE.
- HOLD
  - Update with req=0 → IDLE.
  - Update with req=1, mode=1 → PULSE, counter reloaded.
  - Update with req=1, mode=0 → stays HOLD.
- PULSE
  - Each edge without an update: counter decrements.
  - Edge where the counter goes 1→0: → IDLE, `expired_q` ← 1.
  - Update with req=1, mode=1: counter reloads to PULSE_CYCLES (retrigger).
  - Update with req=1, mode=0 → HOLD.
  - Update with req=0 → IDLE immediately; `expired_q` is not set.
  - An update on the same edge as expiry wins; `expired_q` is not set.
  - Capture on the same edge as expiry: `sr` gets the pre-edge `expired_q`, and `expired_q` ends set (set wins over clear).
- `ijtag_data_in` holds its value after the mux is released; only an update changes it.

Reset (async assert, removal synchronous to TCK), all zero:
- `sr`, `ijtag_so`
- `ijtag_select`, `ijtag_data_in`
- state=IDLE, counter, `pulse_mode_q`, `expired_q`

Reset mid-pulse drops `ijtag_select` asynchronously.

## Timing
- Update at edge k: `ijtag_select` and `ijtag_data_in` are valid after edge k (latency 1). The two change on the same edge, so the mux never sees a select/data mismatch.
- Pulse length: `ijtag_select` is high from after edge k until after edge k+PULSE_CYCLES, i.e. exactly PULSE_CYCLES cycles.
- Scan out: `ijtag_so` reflects `sr[0]` after every edge. A full scan is WIDTH+3 shift cycles.
- Capture samples `observe_data_in` at edge k. A value applied by an update at edge k is observable by a capture at edge k+1 or later.

## Test plan
1. Reset with `ijtag_reset`=0 mid-operation → `ijtag_select`=0, `ijtag_data_in`=0, `ijtag_so`=0 immediately.
2. Shift in data 19'h5A5A5, req=1, mode=0, then update → `ijtag_select`=1 and `ijtag_data_in`=19'h5A5A5 one edge after `ue`. Capture with `observe_data_in`=19'h5A5A5, shift out 22 bits → LSB-first shows data 19'h5A5A5, select 1, mode 0, expired 0.
3. Pulse mode: update with req=1, mode=1 → `ijtag_select` high for exactly 16 cycles, then low. A subsequent capture shows expired=1; a second capture shows expired=0.
4. Retrigger: a second pulse update 10 cycles into a pulse → `ijtag_select` stays high for 26 cycles total. An update with req=0 mid-pulse → low on the next edge, and capture shows expired=0.
5. With `ijtag_sel`=0, toggle `ce`/`se`/`ue` → `sr`, `ijtag_so` and the outputs are unchanged. A running pulse still expires after 16 cycles.
6. `ce`=`se`=1 on the same edge → capture occurs. `se`=`ue`=1 on the same edge → the update applies the pre-shift `sr` contents.
